// File: rtl/month_year_counter.sv
// rtl/month_year_counter.sv - month/year calendar stage with leap-year max_day feedback
module month_year_counter #(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signal,
  input  logic        manual_set,
  input  logic        sel_year,
  input  logic        up,
  input  logic        down,
  output logic [3:0]  month,
  output logic [11:0] year,
  output logic [5:0]  max_day,
  output logic        leap,
  output logic        signal_out
);

  localparam logic [11:0] YMIN = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX = 12'(YEAR_MAX);

  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic        signal_out_q, signal_out_d;
  logic        month_bad;

  assign month_bad = (month_q == 4'd0) || (month_q > 4'd12);

  always_comb begin
    month_d      = month_q;
    year_d       = year_q;
    signal_out_d = 1'b0;
    if (manual_set) begin
      if (up || down) begin
        // A corrupted month is forced back to January on any step
        if (month_bad) begin
          month_d = 4'd1;
        end else if (!sel_year) begin
          if (up) month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
          else    month_d = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
        end
        if (sel_year) begin
          if (up) year_d = (year_q == YMAX) ? YMIN : year_q + 12'd1;
          else    year_d = (year_q == YMIN) ? YMAX : year_q - 12'd1;
        end
      end
    end else if (signal) begin
      if (month_bad) begin
        month_d = 4'd1;
      end else if (month_q == 4'd12) begin
        month_d = 4'd1;
        if (year_q == YMAX) begin
          year_d       = YMIN;
          signal_out_d = 1'b1;
        end else begin
          year_d = year_q + 12'd1;
        end
      end else begin
        month_d = month_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      month_q      <= 4'd1;
      year_q       <= YMIN;
      signal_out_q <= 1'b0;
    end else begin
      month_q      <= month_d;
      year_q       <= year_d;
      signal_out_q <= signal_out_d;
    end
  end

  always_comb begin
    leap = (year_q[1:0] == 2'b00) &&
           (((year_q % 12'd100) != 12'd0) || ((year_q % 12'd400) == 12'd0));
  end

  always_comb begin
    max_day = 6'd31;
    case (month_q)
      4'd4, 4'd6, 4'd9, 4'd11: max_day = 6'd30;
      4'd2:                    max_day = leap ? 6'd29 : 6'd28;
      default:                 max_day = 6'd31;
    endcase
  end

  assign month      = month_q;
  assign year       = year_q;
  assign signal_out = signal_out_q;

endmodule

// File: doc/month_year_counter.md
Name: month_year_counter

Overview:
- Calendar stage directly downstream of the day counter.
- Consumes the day counter's month-carry pulse and maintains month (1..12) and year (YEAR_MIN..YEAR_MAX).
- Feeds max_day back to the day counter, with Gregorian leap-year handling.
- Supports manual up/down setting of either field, and emits a one-cycle wrap pulse when the year range rolls over.

Parameters:
- YEAR_MIN, 2000, lowest representable year; reset value of year.
- YEAR_MAX, 2999, highest representable year; must satisfy YEAR_MIN < YEAR_MAX <= 4095.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- signal  input  1  month-advance pulse; driven by the day counter's signal_out (one cycle wide).
- manual_set  input  1  1 = manual adjust mode; auto advance is ignored while high.
- sel_year  input  1  manual target field: 0 = month, 1 = year.
- up  input  1  manual increment request; sampled every cycle while manual_set = 1.
- down  input  1  manual decrement request; sampled every cycle while manual_set = 1.
- month  output  4  current month, 1..12, registered.
- year  output  12  current year, YEAR_MIN..YEAR_MAX, registered.
- max_day  output  6  days in the current month; combinational from the month/year registers.
- leap  output  1  1 when the current year is a leap year; combinational.
- signal_out  output  1  one-cycle pulse on auto-advance wrap of year YEAR_MAX -> YEAR_MIN.

Behaviour:
- Reset: synchronous, active-high. While rst = 1 at a clock edge:
  - month <= 1; year <= YEAR_MIN; signal_out <= 0.
  - All other inputs are ignored that cycle.
  - Reset mid-adjust or mid-carry discards the pending event.
- signal_out is a registered pulse: it defaults to 0 every cycle and is set only as described below.
- Priority per cycle, highest first: rst, manual_set, signal, hold.
- Manual mode (manual_set = 1):
  - signal is ignored; carries arriving during manual mode are lost, not queued.
  - up and down are level-sampled: each cycle with up = 1 steps once. up = 1 and down = 1 together: up wins.
  - sel_year = 0, up: month 12 -> 1, else month + 1. Year is unchanged.
  - sel_year = 0, down: month 1 -> 12, else month - 1. Year is unchanged.
  - sel_year = 1, up: year YEAR_MAX -> YEAR_MIN, else year + 1.
  - sel_year = 1, down: year YEAR_MIN -> YEAR_MAX, else year - 1.
  - Month is unchanged in all sel_year = 1 steps.
  - signal_out stays 0 in manual mode, including on manual year wraps.
- Auto mode (manual_set = 0, signal = 1):
  - month < 12: month + 1.
  - month == 12: month <= 1 and the year advances.
  - Year advance when year < YEAR_MAX: year + 1.
  - Year advance when year == YEAR_MAX: year <= YEAR_MIN and signal_out <= 1 for exactly that cycle.
  - Latency: month/year update on the edge that samples signal; signal_out is visible the cycle after that edge.
- Hold: no rst, manual_set, or signal → all registers keep their values.
- Leap rule: leap = (year mod 4 == 0) and ((year mod 100 != 0) or (year mod 400 == 0)).
  - Constant-divisor modulo only; no runtime divider.
- max_day:
  - Months 1, 3, 5, 7, 8, 10, 12 -> 31.
  - Months 4, 6, 9, 11 -> 30.
  - Month 2 -> 29 if leap, else 28.
  - max_day changes in the same cycle as month/year, so the day counter sees the new limit on its next edge.
  - Clamping an existing day above the new max_day is the day counter's responsibility.
- Illegal month register value (0 or 13..15, only reachable by fault): max_day = 31; next auto or manual step forces month to 1.
- Width rules:
  - All year arithmetic is done in 12 bits unsigned.
  - Wrap compares use == against the parameters; no overflow reliance.

Test Plan:
1. Reset → month = 1, year = 2000, max_day = 31, leap = 1, signal_out = 0. Assert rst with state month = 7, year = 2500 → next edge gives 1/2000.
2. Auto carry chain: preload month = 12, year = 2023 via manual; pulse signal once → month = 1, year = 2024, leap = 1, signal_out = 0.
3. Leap / max_day sweep, month = 2 in each year:
   - 2000 → max_day = 29.
   - 2100 → 28.
   - 2400 → 29.
   - 2023 → 28.
   - Then months 4 and 9 → 30; months 1 and 12 → 31.
4. Year wrap: month = 12, year = 2999, pulse signal → month = 1, year = 2000, signal_out = 1 for exactly one cycle, then 0.
5. Manual mode:
   - sel_year = 0, month = 1, down → month = 12, year unchanged.
   - sel_year = 1, year = 2000, down → 2999, signal_out stays 0.
   - up and down both high → increment taken.
6. Priority: manual_set = 1 with signal = 1 and up = 0 → no change; the signal is lost. Drop manual_set and pulse signal → normal month advance.
